// File: rtl/psum_accum_quant.sv
// Accumulates per-position 16-bit partial sums over NUM_PASS passes, then quantises each lane to 8 bits
// (arithmetic shift, ReLU, saturate) and queues packed {qa, qb} words in a first-word-fall-through FIFO.
module psum_accum_quant #(
    parameter int NUM_PIX    = 4,
    parameter int NUM_PASS   = 4,
    parameter int ACC_W      = 24,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [15:0]                       outa,
    input  logic [15:0]                       outb,
    output logic [15:0]                       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              done,
    output logic                              err_flag
);

    localparam int PIX_W  = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int PASS_W = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [PIX_W-1:0]         pix_idx_q, pix_idx_d;
    logic [PASS_W-1:0]        pass_idx_q, pass_idx_d;
    logic signed [ACC_W-1:0]  acc_a_q [NUM_PIX];
    logic signed [ACC_W-1:0]  acc_a_d [NUM_PIX];
    logic signed [ACC_W-1:0]  acc_b_q [NUM_PIX];
    logic signed [ACC_W-1:0]  acc_b_d [NUM_PIX];
    logic [15:0]              mem_q [FIFO_DEPTH];
    logic [15:0]              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     err_q, err_d;

    logic                     last_pix, last_pass, fifo_full, fifo_empty;
    logic                     accept, push, pop;
    logic signed [ACC_W-1:0]  sa, sb, sum_a, sum_b;

    // Shift first, then clamp: negative -> 0, anything above 8 bits -> 255.
    function automatic logic [7:0] quant(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] t;
        t = x >>> SHIFT;
        if (t[ACC_W-1])
            return 8'd0;
        else if (|t[ACC_W-2:8])
            return 8'hFF;
        else
            return t[7:0];
    endfunction

    assign last_pix   = (pix_idx_q == PIX_W'(NUM_PIX - 1));
    assign last_pass  = (pass_idx_q == PASS_W'(NUM_PASS - 1));
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    assign in_ready   = (state_q == S_ACCUM) && !(last_pass && fifo_full);
    assign accept     = in_valid && in_ready;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 16'd0;
    assign fifo_count = count_q;
    assign busy       = (state_q == S_ACCUM);
    assign done       = (state_q == S_DONE);
    assign err_flag   = err_q;

    assign sa    = {{(ACC_W-16){outa[15]}}, outa};
    assign sb    = {{(ACC_W-16){outb[15]}}, outb};
    // The first pass overwrites, so a restarted job never sees stale sums.
    assign sum_a = (pass_idx_q == '0) ? sa : acc_a_q[pix_idx_q] + sa;
    assign sum_b = (pass_idx_q == '0) ? sb : acc_b_q[pix_idx_q] + sb;

    always_comb begin
        state_d    = state_q;
        pix_idx_d  = pix_idx_q;
        pass_idx_d = pass_idx_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        err_d      = err_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ACCUM;
                    pix_idx_d  = '0;
                    pass_idx_d = '0;
                    err_d      = 1'b0;
                end else if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            S_ACCUM: begin
                if (start) begin
                    pix_idx_d  = '0;
                    pass_idx_d = '0;
                    err_d      = 1'b0;
                end else if (accept) begin
                    acc_a_d[pix_idx_q] = sum_a;
                    acc_b_d[pix_idx_q] = sum_b;
                    push = last_pass;
                    if (last_pix) begin
                        pix_idx_d = '0;
                        if (last_pass)
                            state_d = S_DONE;
                        else
                            pass_idx_d = pass_idx_q + PASS_W'(1);
                    end else begin
                        pix_idx_d = pix_idx_q + PIX_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (in_valid)
                    err_d = 1'b1;
                if (fifo_empty)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {quant(sum_a), quant(sum_b)};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pix_idx_q  <= '0;
            pass_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_PIX; i++) begin
                acc_a_q[i] <= '0;
                acc_b_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pix_idx_q  <= pix_idx_d;
            pass_idx_q <= pass_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_psum_accum_quant.sv
// Bench for psum_accum_quant: default instance plus a FIFO_DEPTH=2 instance for backpressure,
// checked against a plain-arithmetic accumulate/quantise model.
module tb_psum_accum_quant;

    localparam int NP = 4;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] outa = 16'd0;
    logic [15:0] outb = 16'd0;
    logic        sel = 1'b0;

    logic        d0_in_ready, d0_out_valid, d0_busy, d0_done, d0_err;
    logic [15:0] d0_out_data;
    logic [3:0]  d0_fifo_count;
    logic        d1_in_ready, d1_out_valid, d1_busy, d1_done, d1_err;
    logic [15:0] d1_out_data;
    logic [1:0]  d1_fifo_count;

    logic        obs_in_ready, obs_out_valid, obs_busy, obs_done, obs_err;
    logic [15:0] obs_out_data;
    logic [3:0]  obs_fifo_count;

    int checks = 0;
    int failures = 0;

    longint      m_acc_a [NP];
    longint      m_acc_b [NP];
    int          m_pix = 0;
    int          m_pass = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    psum_accum_quant u_dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid & ~sel),
        .in_ready(d0_in_ready), .outa(outa), .outb(outb), .out_data(d0_out_data),
        .out_valid(d0_out_valid), .out_ready(out_ready & ~sel), .fifo_count(d0_fifo_count),
        .busy(d0_busy), .done(d0_done), .err_flag(d0_err)
    );

    psum_accum_quant #(.FIFO_DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid & sel),
        .in_ready(d1_in_ready), .outa(outa), .outb(outb), .out_data(d1_out_data),
        .out_valid(d1_out_valid), .out_ready(out_ready & sel), .fifo_count(d1_fifo_count),
        .busy(d1_busy), .done(d1_done), .err_flag(d1_err)
    );

    assign obs_in_ready   = sel ? d1_in_ready   : d0_in_ready;
    assign obs_out_valid  = sel ? d1_out_valid  : d0_out_valid;
    assign obs_out_data   = sel ? d1_out_data   : d0_out_data;
    assign obs_fifo_count = sel ? {2'b00, d1_fifo_count} : d0_fifo_count;
    assign obs_busy       = sel ? d1_busy : d0_busy;
    assign obs_done       = sel ? d1_done : d0_done;
    assign obs_err        = sel ? d1_err  : d0_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap24(input longint x);
        longint y;
        y = x & 64'hFF_FFFF;
        if (y >= 8388608) y = y - 16777216;
        return y;
    endfunction

    function automatic logic [7:0] mquant(input longint x);
        longint t;
        t = x >>> 8;
        if (t < 0) return 8'd0;
        if (t > 255) return 8'd255;
        return t[7:0];
    endfunction

    // Reference behaviour of one accepted sample.
    task automatic model_accept(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m_pass == 0) begin
            m_acc_a[m_pix] = sa;
            m_acc_b[m_pix] = sb;
        end else begin
            m_acc_a[m_pix] = wrap24(m_acc_a[m_pix] + sa);
            m_acc_b[m_pix] = wrap24(m_acc_b[m_pix] + sb);
        end
        if (m_pass == NS - 1)
            exp_q.push_back({mquant(m_acc_a[m_pix]), mquant(m_acc_b[m_pix])});
        m_pix++;
        if (m_pix == NP) begin
            m_pix = 0;
            if (m_pass < NS - 1) m_pass++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        outa = a;
        outb = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (obs_in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", {31'd0, obs_in_ready}, 32'd1);
                break;
            end
        end
        if (obs_in_ready) model_accept(a, b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_pix = 0;
        m_pass = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while ((obs_busy || obs_done || obs_fifo_count != 0) && n < 300);
        chk("idle_busy", {31'd0, obs_busy}, 32'd0);
        chk("idle_done", {31'd0, obs_done}, 32'd0);
        chk("idle_count", {28'd0, obs_fifo_count}, 32'd0);
        chk("words_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every pop is compared with the head of the expected-word queue.
    always @(negedge clk) begin
        if (!rst && obs_out_valid && out_ready) begin
            if (exp_q.size() > 0)
                chk("pop_data", {16'd0, obs_out_data}, {16'd0, exp_q.pop_front()});
            else
                chk("unexpected_pop", {31'd0, obs_out_valid}, 32'd0);
        end
    end

    initial begin
        // Reset state
        idle_cycles(3);
        chk("rst_in_ready", {31'd0, obs_in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, obs_out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, obs_out_data}, 32'd0);
        chk("rst_fifo_count", {28'd0, obs_fifo_count}, 32'd0);
        chk("rst_busy", {31'd0, obs_busy}, 32'd0);
        chk("rst_done", {31'd0, obs_done}, 32'd0);
        chk("rst_err", {31'd0, obs_err}, 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // start and in_valid together in IDLE: start wins
        start = 1'b1;
        in_valid = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        in_valid = 1'b0;
        chk("start_wins_err", {31'd0, obs_err}, 32'd0);
        chk("start_wins_busy", {31'd0, obs_busy}, 32'd1);

        // Nominal job
        out_ready = 1'b1;
        do_start();
        chk("t2_in_ready", {31'd0, obs_in_ready}, 32'd1);
        for (int i = 0; i < NP * NS; i++) send(16'h0100, 16'h0080);
        chk("t2_done", {31'd0, obs_done}, 32'd1);
        chk("t2_in_ready_done", {31'd0, obs_in_ready}, 32'd0);
        wait_idle();

        // Clamp: lane A negative -> 0, lane B large -> 255
        do_start();
        for (int i = 0; i < NP * NS; i++) send(16'hFF00, 16'h7FFF);
        wait_idle();

        // Protocol error in IDLE
        in_valid = 1'b1;
        idle_cycles(1);
        in_valid = 1'b0;
        chk("t6_err_set", {31'd0, obs_err}, 32'd1);
        chk("t6_no_push", {28'd0, obs_fifo_count}, 32'd0);
        chk("t6_no_valid", {31'd0, obs_out_valid}, 32'd0);
        do_start();
        chk("t6_err_clear", {31'd0, obs_err}, 32'd0);
        chk("t6_busy", {31'd0, obs_busy}, 32'd1);

        // Random samples with random consumer stalls and input gaps
        for (int i = 0; i < NP * NS; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            idle_cycles($urandom_range(0, 2));
            send(16'($urandom), 16'($urandom));
        end
        wait_idle();

        // Restart mid-job
        do_start();
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom));
        do_start();
        chk("t5_busy", {31'd0, obs_busy}, 32'd1);
        for (int i = 0; i < NP * NS; i++) send(16'($urandom_range(0, 16'h3FFF)), 16'($urandom));
        wait_idle();

        // Backpressure on the 2-deep instance
        sel = 1'b1;
        out_ready = 1'b0;
        idle_cycles(1);
        do_start();
        for (int i = 0; i < NP * NS - 2; i++) send(16'($urandom), 16'($urandom));
        @(negedge clk);
        chk("t4_in_ready_low", {31'd0, obs_in_ready}, 32'd0);
        chk("t4_count_full", {28'd0, obs_fifo_count}, 32'd2);
        chk("t4_out_valid", {31'd0, obs_out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) send(16'($urandom), 16'($urandom));
        wait_idle();
        sel = 1'b0;
        idle_cycles(1);

        // Asynchronous reset mid-job with words queued
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < NP * NS - 2; i++) send(16'h0100, 16'h0080);
        chk("t1_pre_count", {28'd0, obs_fifo_count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_in_ready", {31'd0, obs_in_ready}, 32'd0);
        chk("t1_out_valid", {31'd0, obs_out_valid}, 32'd0);
        chk("t1_out_data", {16'd0, obs_out_data}, 32'd0);
        chk("t1_fifo_count", {28'd0, obs_fifo_count}, 32'd0);
        chk("t1_busy", {31'd0, obs_busy}, 32'd0);
        exp_q.delete();
        m_pix = 0;
        m_pass = 0;
        idle_cycles(2);
        rst = 1'b0;
        out_ready = 1'b1;
        idle_cycles(5);
        chk("t1_post_valid", {31'd0, obs_out_valid}, 32'd0);
        chk("t1_post_count", {28'd0, obs_fifo_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
